// File: rtl/seq_detector_param_if.sv
// Bus between a serial bit source / config master and the pattern detector.
// Carries configuration, the qualified bit stream and match/statistics outputs.
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               cfg_load_i;
  logic [MAX_LEN-1:0] pattern_i;
  logic [LEN_W-1:0]   pat_len_i;
  logic               overlap_en_i;
  logic               in_valid_i;
  logic               in_bit_i;
  logic               cnt_clr_i;
  logic               match_o;
  logic [CNT_W-1:0]   match_cnt_o;
  logic               cnt_sat_o;
  logic               cfg_err_o;

  modport slave (
    input  cfg_load_i, pattern_i, pat_len_i, overlap_en_i, in_valid_i, in_bit_i, cnt_clr_i,
    output match_o, match_cnt_o, cnt_sat_o, cfg_err_o
  );

  modport master (
    output cfg_load_i, pattern_i, pat_len_i, overlap_en_i, in_valid_i, in_bit_i, cnt_clr_i,
    input  match_o, match_cnt_o, cnt_sat_o, cfg_err_o
  );
endinterface

// File: rtl/seq_detector_param.sv
// Serial pattern detector with runtime pattern (1..MAX_LEN bits), overlap select,
// registered match pulse and a saturating match counter.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_detector_param_if.slave  bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {UNCFG, SEARCH, HIT} state_e;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] hist_nx, mask;
  logic [LEN_W-1:0]   fill_nx;
  logic               legal, hit;

  always_comb begin
    hist_nx = {hist_q[MAX_LEN-2:0], bus.in_bit_i};
    fill_nx = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len_q));
    legal = (bus.pat_len_i != '0) && (bus.pat_len_i <= LEN_W'(MAX_LEN));
    // A completing bit only counts when it is not swallowed by a same-cycle reload.
    hit = !bus.cfg_load_i && bus.in_valid_i && (state_q != UNCFG) &&
          (fill_nx >= len_q) && (((hist_nx ^ pat_q) & mask) == '0);
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    err_d   = err_q;
    if (bus.cfg_load_i) begin
      pat_d   = bus.pattern_i;
      len_d   = bus.pat_len_i;
      ovl_d   = bus.overlap_en_i;
      hist_d  = '0;
      fill_d  = '0;
      err_d   = !legal;
      state_d = legal ? SEARCH : UNCFG;
    end else if (bus.in_valid_i && state_q != UNCFG) begin
      hist_d  = hist_nx;
      fill_d  = fill_nx;
      state_d = hit ? HIT : SEARCH;
      if (hit && !ovl_q) begin
        hist_d = '0;
        fill_d = '0;
      end
    end else if (state_q == HIT) begin
      state_d = SEARCH;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (bus.cnt_clr_i) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (hit && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
      sat_d = sat_q | (&cnt_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNCFG;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

  assign bus.match_o     = (state_q == HIT);
  assign bus.match_cnt_o = cnt_q;
  assign bus.cnt_sat_o   = sat_q;
  assign bus.cfg_err_o   = err_q;
endmodule
